// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential 5x5 unsigned multiplier.
// One partial-product add per clock through a 5-bit halfAdder/fullAdder
// ripple chain; the result is ready 5 clocks after start is accepted.
//
// Ports:
//   clk_i      rising-edge clock
//   reset_i    synchronous active-high reset
//   start_i    request a multiply (accepted only when not busy)
//   a_i[4:0]   multiplicand, sampled on the accepting edge
//   b_i[4:0]   multiplier, sampled on the accepting edge
//   busy_o     high while the operation is iterating
//   done_o     one-cycle pulse, product_o valid while high
//   product_o  registered a*b, held until the next final iteration

module halfAdder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module fullAdder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);
  logic s1_s, c1_s, c2_s;

  halfAdder u_ha0 (.a_i(a_i),  .b_i(b_i),   .s_o(s1_s), .c_o(c1_s));
  halfAdder u_ha1 (.a_i(s1_s), .b_i(cin_i), .s_o(s_o),  .c_o(c2_s));

  assign cout_o = c1_s | c2_s;
endmodule

module shift_add_multiplier (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [4:0] a_i,
  input  logic [4:0] b_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [9:0] product_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  m_q, m_d;
  // The top bit of the 6-bit partial high half is always zero after the
  // right shift, so only its lower five bits are stored.
  logic [4:0]  acc_q, acc_d;
  logic [4:0]  q_q, q_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [9:0]  product_q, product_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [4:0]  add_b_s;
  logic [4:0]  sum_s;
  logic [5:0]  carry_s;

  // Multiplicand gated by the current multiplier LSB.
  assign add_b_s    = q_q[0] ? m_q : 5'b00000;
  assign carry_s[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_rca
      fullAdder u_fa (
        .a_i   (acc_q[gi]),
        .b_i   (add_b_s[gi]),
        .cin_i (carry_s[gi]),
        .s_o   (sum_s[gi]),
        .cout_o(carry_s[gi+1])
      );
    end
  endgenerate

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          m_d     = a_i;
          q_d     = b_i;
          acc_d   = 5'b00000;
          cnt_d   = 3'd0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // {acc, q} <= {0, cout, sum, q[4:1]}
        acc_d = {carry_s[5], sum_s[4:1]};
        q_d   = {sum_s[0], q_q[4:1]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd4) begin
          product_d = {carry_s[5], sum_s, q_q[4:1]};
          state_d   = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      m_q       <= 5'b00000;
      acc_q     <= 5'b00000;
      q_q       <= 5'b00000;
      cnt_q     <= 3'd0;
      product_q <= 10'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = product_q;

endmodule
